// File: rtl/pio_input_frontend_pkg.sv
// Shared constants for the PIO input front end: default widths and the
// bit layout of the button word and host acknowledge word.
package pio_frontend_pkg;

   localparam int NUM_SW_DEFAULT  = 18;
   localparam int NUM_KEY_DEFAULT = 4;
   localparam int WORD_W          = 32;

   localparam int BW_LEVEL_LSB    = 0;
   localparam int BW_EVENT_LSB    = 4;
   localparam int BW_COUNT_LSB    = 16;
   localparam int BW_COUNT_W      = 8;
   localparam int BW_ACK_BIT      = 31;

   localparam int ACK_TOGGLE_BIT  = 31;

endpackage

// File: rtl/pio_input_frontend_if.sv
// Board-side raw inputs, host acknowledge word and the two PIO-facing words.
// The slave modport is the front end; the master modport is the board/host side.
interface pio_input_frontend_if
   import pio_frontend_pkg::*;
#(
   parameter int NUM_SW  = NUM_SW_DEFAULT,
   parameter int NUM_KEY = NUM_KEY_DEFAULT
);

   logic [NUM_SW-1:0]  sw_raw;
   logic [NUM_KEY-1:0] key_n_raw;
   logic [WORD_W-1:0]  ack_word;
   logic [WORD_W-1:0]  switch_word;
   logic [WORD_W-1:0]  button_word;

   modport master (
      output sw_raw, key_n_raw, ack_word,
      input  switch_word, button_word
   );

   modport slave (
      input  sw_raw, key_n_raw, ack_word,
      output switch_word, button_word
   );

endinterface

// File: rtl/pio_input_frontend_debounce_bit.sv
// One input bit: 2-flop synchronizer, optional polarity flip, then a
// stability counter that accepts a new level after DEBOUNCE_CYCLES mismatches.
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit IDLE_RAW        = 1'b0,
   parameter bit INVERT          = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_count;
   logic             w_sample;

   assign w_sample = r_sync[1] ^ INVERT;
   assign o_level  = r_level;

   // Any cycle where the synchronized value agrees with the held level restarts qualification.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= {2{IDLE_RAW}};
         r_level <= IDLE_RAW ^ INVERT;
         r_count <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         if (w_sample == r_level) begin
            r_count <= '0;
         end else if (r_count == CNT_LAST) begin
            r_level <= w_sample;
            r_count <= '0;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pio_input_frontend.sv
// Debounced switch/button front end for two PIO input ports, with sticky
// press events, a press counter and a toggle-based host acknowledge.
module pio_input_frontend
   import pio_frontend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NUM_SW          = NUM_SW_DEFAULT,
   parameter int NUM_KEY         = NUM_KEY_DEFAULT
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   pio_input_frontend_if.slave  bus
);

   logic [1:0]            r_rstSync;
   logic                  w_rstN;
   logic [NUM_SW-1:0]     w_swDeb;
   logic [NUM_SW-1:0]     r_swLevel;
   logic [NUM_KEY-1:0]    w_keyDeb;
   logic [NUM_KEY-1:0]    r_keyLevel;
   logic [NUM_KEY-1:0]    r_event;
   logic [NUM_KEY-1:0]    w_press;
   logic [NUM_KEY-1:0]    w_clearMask;
   logic [BW_COUNT_W-1:0] r_pressCnt;
   logic [BW_COUNT_W-1:0] w_pressNum;
   logic                  r_ackCopy;
   logic                  w_ackToggle;
   logic [WORD_W-1:0]     w_switchWord;
   logic [WORD_W-1:0]     w_buttonWord;

   // Reset asserts immediately but releases two clocks later, clean of the clock edge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_rstSync <= '0;
      else                r_rstSync <= {r_rstSync[0], 1'b1};
   end
   assign w_rstN = r_rstSync[1];

   for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_RAW(1'b0), .INVERT(1'b0)) u_deb (
         .i_clk(clk_clk), .i_rst_n(w_rstN), .i_raw(bus.sw_raw[g]), .o_level(w_swDeb[g])
      );
   end

   for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_RAW(1'b1), .INVERT(1'b1)) u_deb (
         .i_clk(clk_clk), .i_rst_n(w_rstN), .i_raw(bus.key_n_raw[g]), .o_level(w_keyDeb[g])
      );
   end

   // r_keyLevel is the previous debounced level, so a rise here is a fresh press.
   assign w_press     = w_keyDeb & ~r_keyLevel;
   assign w_ackToggle = bus.ack_word[ACK_TOGGLE_BIT] != r_ackCopy;
   assign w_clearMask = w_ackToggle ? bus.ack_word[NUM_KEY-1:0] : '0;

   always_comb begin
      w_pressNum = '0;
      for (int i = 0; i < NUM_KEY; i++) begin
         w_pressNum = w_pressNum + BW_COUNT_W'(w_press[i]);
      end
   end

   // Clear is applied before set so a press coinciding with its own clear survives.
   always_ff @(posedge clk_clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_swLevel  <= '0;
         r_keyLevel <= '0;
         r_event    <= '0;
         r_pressCnt <= '0;
         r_ackCopy  <= 1'b0;
      end else begin
         r_swLevel  <= w_swDeb;
         r_keyLevel <= w_keyDeb;
         r_event    <= (r_event & ~w_clearMask) | w_press;
         r_pressCnt <= r_pressCnt + w_pressNum;
         if (w_ackToggle) r_ackCopy <= bus.ack_word[ACK_TOGGLE_BIT];
      end
   end

   always_comb begin
      w_switchWord                               = '0;
      w_switchWord[NUM_SW-1:0]                   = r_swLevel;
      w_buttonWord                               = '0;
      w_buttonWord[BW_LEVEL_LSB +: NUM_KEY]      = r_keyLevel;
      w_buttonWord[BW_EVENT_LSB +: NUM_KEY]      = r_event;
      w_buttonWord[BW_COUNT_LSB +: BW_COUNT_W]   = r_pressCnt;
      w_buttonWord[BW_ACK_BIT]                   = r_ackCopy;
   end

   assign bus.switch_word = w_switchWord;
   assign bus.button_word = w_buttonWord;

endmodule

// File: doc/pio_input_frontend.md
PIO_INPUT_FRONTEND -- requirements
Module: pio_input_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable clk_clk cycles required to accept a new input level (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter NUM_SW, default 18, number of slide switches.
REQ-003 Parameter NUM_KEY, default 4, number of push buttons.
REQ-004 clk_clk  in  1  single system clock; all state in this domain.
REQ-005 reset_reset_n  in  1  asynchronous assert, active-low reset.
REQ-006 sw_raw  in  NUM_SW  raw board switches, asynchronous, active-high.
REQ-007 key_n_raw  in  NUM_KEY  raw board push buttons, asynchronous, active-low (0 = pressed).
REQ-008 ack_word  in  32  host acknowledge word from the host-written PIO; bit 31 = ack toggle, bits [NUM_KEY-1:0] = clear mask.
REQ-009 switch_word  out  32  to switch PIO input; bits [NUM_SW-1:0] debounced switches, remaining bits 0.
REQ-010 button_word  out  32  to button PIO input; [3:0] debounced pressed level, [7:4] sticky press events, [15:8] 0, [23:16] press counter, [30:24] 0, [31] ack echo.

Function
REQ-011 Each raw input bit SHALL pass through a 2-flop synchronizer; key bits are inverted after synchronization so that 1 = pressed.
REQ-012 Each bit SHALL hold a debounced level and a counter; the counter increments each cycle synchronized != debounced and clears to 0 on any cycle they are equal.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A raw level held steady SHALL appear on switch_word/button_word exactly DEBOUNCE_CYCLES+3 clk_clk rising edges after the raw change; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never appear.
REQ-015 A debounced key transition 0->1 SHALL set its sticky event bit in button_word[4+i] on the cycle after the debounced level changes; release SHALL NOT affect the event bit.
REQ-016 The press counter button_word[23:16] SHALL add the number of keys with a new press event that cycle (0..NUM_KEY), modulo 256 wrap-around.
REQ-017 Ack handshake: a registered copy of ack_word[31] is kept; when ack_word[31] differs from it, the block SHALL clear every event bit whose mask bit is 1, update the copy, and drive button_word[31] equal to the new ack_word[31], all in the next cycle.
REQ-018 The host SHALL treat button_word[31] == its written toggle as "ack accepted"; the block accepts at most one ack per toggle.
REQ-019 Simultaneous press event and masked clear on the same key in the same cycle: set SHALL win (event remains 1).
REQ-020 ack_word changes without a bit-31 toggle SHALL have no effect; mask bits above NUM_KEY-1 are ignored.
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-022 On reset_reset_n low, the block SHALL asynchronously force: synchronizers to the idle level (switch 0, key released), debounced levels to idle, counters 0, event bits 0, press counter 0, ack copy 0, switch_word = 0, button_word = 0.
REQ-023 Reset release SHALL be synchronized internally; if ack_word[31] = 1 at release, one ack is accepted on the first active cycle (the ack copy resets to 0).
REQ-024 A reset mid-debounce SHALL discard the pending count; the input restarts qualification from the idle level.

Structure
REQ-025 Package pio_frontend_pkg SHALL hold NUM_SW/NUM_KEY defaults, the button_word field bit-index constants and the ack toggle bit index.
REQ-026 Sub-module debounce_bit (synchronizer + counter + debounced level, parameterised by DEBOUNCE_CYCLES and idle value) SHALL be instantiated NUM_SW+NUM_KEY times.
REQ-027 Event, counter and ack logic SHALL live in pio_input_frontend; target 120-400 lines total.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Reset, sw_raw = 0x3FFFF held -> switch_word = 0 for 6 edges, 0x0003FFFF on edge 7.
REQ-029 key_n_raw[0] low for 3 cycles then high -> button_word stays 0x00000000.
REQ-030 key_n_raw[2] low held -> at edge 7 button_word = 0x00010044; release held -> at 7 edges after release 0x00010040.
REQ-031 With event bits 0x5 set, ack_word = 0x80000001 -> next cycle button_word[7:4] = 0x4, [31] = 1; ack_word unchanged thereafter -> no further clears.
REQ-032 Key 1 new press coincident with ack toggle mask 0x2 -> event bit 5 remains 1, counter +1.
REQ-033 Preload counter to 0xFF via 255 presses, one more press -> counter 0x00; assert reset mid-debounce -> all outputs 0 immediately.
